// File: rtl/ball_controller_if.sv
// rtl/ball_controller_if.sv - frame-level game signals between renderer side and ball controller
interface ball_controller_if;
    logic        frame_tick;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        restart;
    logic [1:0]  collision;
    logic [1:0]  touchdown;
    logic [31:0] currentBallRow;
    logic [31:0] currentBallCol;
    logic        change;
    logic        countdown;
    logic        isdelay;
    logic        win;
    logic        lose;
    logic [1:0]  lives_left;

    modport master (
        output frame_tick, btn_up, btn_down, btn_left, btn_right, restart, collision, touchdown,
        input  currentBallRow, currentBallCol, change, countdown, isdelay, win, lose, lives_left
    );

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_left, btn_right, restart, collision, touchdown,
        output currentBallRow, currentBallCol, change, countdown, isdelay, win, lose, lives_left
    );
endinterface

// File: rtl/ball_controller.sv
// rtl/ball_controller.sv - per-frame maze game engine: ball movement, wall hits, lives, win/lose
module ball_controller #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_RADIUS  = 8,
    parameter int START_ROW    = 240,
    parameter int START_COL    = 24,
    parameter int STEP         = 2,
    parameter int COUNT_FRAMES = 180,
    parameter int DELAY_FRAMES = 30,
    parameter int LIVES        = 3
) (
    input  logic              pixel_clk,
    input  logic              reset,
    ball_controller_if.slave  bus
);
    localparam int ROW_MAX = SCREEN_H - 1 - BALL_RADIUS;
    localparam int COL_MAX = SCREEN_W - 1 - BALL_RADIUS;

    typedef enum logic [2:0] {COUNTDOWN, PLAY, DELAY, WIN, LOSE} state_t;

    state_t      state;
    logic [31:0] row, col, prev_row, prev_col;
    logic [31:0] moved_row, moved_col;
    logic [15:0] frame_cnt;
    logic [1:0]  lives;
    logic        hit_seen, touch_seen, change, countdown, isdelay, win, lose;
    logic        hit, touch;

    // Flags raised on the tick cycle itself still count for this frame.
    assign hit   = hit_seen   | (bus.collision != 2'd0);
    assign touch = touch_seen | (bus.touchdown != 2'd0);

    // Underflow is caught before subtracting so the unsigned position never wraps.
    always_comb begin
        moved_row = row;
        moved_col = col;
        if (bus.btn_up && !bus.btn_down)
            moved_row = (row < 32'(BALL_RADIUS + STEP)) ? 32'(BALL_RADIUS) : row - 32'(STEP);
        else if (bus.btn_down && !bus.btn_up)
            moved_row = (row + 32'(STEP) > 32'(ROW_MAX)) ? 32'(ROW_MAX) : row + 32'(STEP);
        if (bus.btn_left && !bus.btn_right)
            moved_col = (col < 32'(BALL_RADIUS + STEP)) ? 32'(BALL_RADIUS) : col - 32'(STEP);
        else if (bus.btn_right && !bus.btn_left)
            moved_col = (col + 32'(STEP) > 32'(COL_MAX)) ? 32'(COL_MAX) : col + 32'(STEP);
    end

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state      <= COUNTDOWN;
            row        <= 32'(START_ROW);
            col        <= 32'(START_COL);
            prev_row   <= 32'(START_ROW);
            prev_col   <= 32'(START_COL);
            frame_cnt  <= '0;
            lives      <= 2'(LIVES);
            hit_seen   <= 1'b0;
            touch_seen <= 1'b0;
            change     <= 1'b0;
            countdown  <= 1'b1;
            isdelay    <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
        end else begin
            change <= 1'b0;
            if (bus.restart) begin
                state      <= COUNTDOWN;
                row        <= 32'(START_ROW);
                col        <= 32'(START_COL);
                prev_row   <= 32'(START_ROW);
                prev_col   <= 32'(START_COL);
                frame_cnt  <= '0;
                lives      <= 2'(LIVES);
                hit_seen   <= 1'b0;
                touch_seen <= 1'b0;
                change     <= (row != 32'(START_ROW)) || (col != 32'(START_COL));
                countdown  <= 1'b1;
                isdelay    <= 1'b0;
                win        <= 1'b0;
                lose       <= 1'b0;
            end else if (bus.frame_tick) begin
                hit_seen   <= 1'b0;
                touch_seen <= 1'b0;
                case (state)
                    COUNTDOWN: begin
                        if (frame_cnt == 16'(COUNT_FRAMES - 1)) begin
                            state     <= PLAY;
                            frame_cnt <= '0;
                            countdown <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                    PLAY: begin
                        if (touch) begin
                            state <= WIN;
                            win   <= 1'b1;
                        end else if (hit) begin
                            lives  <= lives - 2'd1;
                            row    <= prev_row;
                            col    <= prev_col;
                            change <= (prev_row != row) || (prev_col != col);
                            if (lives == 2'd1) begin
                                state <= LOSE;
                                lose  <= 1'b1;
                            end else begin
                                state     <= DELAY;
                                isdelay   <= 1'b1;
                                frame_cnt <= '0;
                            end
                        end else begin
                            prev_row <= row;
                            prev_col <= col;
                            row      <= moved_row;
                            col      <= moved_col;
                            change   <= (moved_row != row) || (moved_col != col);
                        end
                    end
                    DELAY: begin
                        if (frame_cnt == 16'(DELAY_FRAMES - 1)) begin
                            state     <= PLAY;
                            frame_cnt <= '0;
                            isdelay   <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                if (bus.collision != 2'd0) hit_seen   <= 1'b1;
                if (bus.touchdown != 2'd0) touch_seen <= 1'b1;
            end
        end
    end

    assign bus.currentBallRow = row;
    assign bus.currentBallCol = col;
    assign bus.change         = change;
    assign bus.countdown      = countdown;
    assign bus.isdelay        = isdelay;
    assign bus.win            = win;
    assign bus.lose           = lose;
    assign bus.lives_left     = lives;
endmodule

// File: tb/tb_ball_controller.sv
// tb/tb_ball_controller.sv - scoreboard bench for ball_controller with a frame-level game model
module tb_ball_controller;
    localparam int SCREEN_W = 640, SCREEN_H = 480, R = 8;
    localparam int START_ROW = 240, START_COL = 24, STEP = 2;
    localparam int COUNT_FRAMES = 180, DELAY_FRAMES = 30, LIVES = 3;

    typedef enum {G_COUNT, G_PLAY, G_FREEZE, G_WON, G_LOST} game_mode_e;
    typedef struct {
        int stamp;
        int row, col, lives;
        bit change, countdown, isdelay, win, lose;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    game_mode_e m_mode;
    int m_row, m_col, m_prev_r, m_prev_c, m_lives, m_left;
    bit m_hit, m_touch;

    ball_controller_if bus();

    ball_controller #(
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .BALL_RADIUS(R),
        .START_ROW(START_ROW), .START_COL(START_COL), .STEP(STEP),
        .COUNT_FRAMES(COUNT_FRAMES), .DELAY_FRAMES(DELAY_FRAMES), .LIVES(LIVES)
    ) dut (
        .pixel_clk(clk),
        .reset(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int dir(input bit neg, input bit pos);
        if (neg && !pos) return -STEP;
        if (pos && !neg) return STEP;
        return 0;
    endfunction

    function automatic void model_restart();
        m_mode = G_COUNT;
        m_left = COUNT_FRAMES;
        m_row = START_ROW; m_col = START_COL;
        m_prev_r = START_ROW; m_prev_c = START_COL;
        m_lives = LIVES;
        m_hit = 0; m_touch = 0;
    endfunction

    // Monitor: pops the expected snapshot due for this cycle and compares every output.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.currentBallRow !== 32'(e.row) || bus.currentBallCol !== 32'(e.col) ||
                bus.change !== e.change || bus.countdown !== e.countdown ||
                bus.isdelay !== e.isdelay || bus.win !== e.win || bus.lose !== e.lose ||
                bus.lives_left !== 2'(e.lives)) begin
                n_fail++;
                $display("FAIL scoreboard cyc=%0d got row=%0d col=%0d chg=%b cd=%b dl=%b win=%b lose=%b lives=%0d expected row=%0d col=%0d chg=%b cd=%b dl=%b win=%b lose=%b lives=%0d",
                         cyc, bus.currentBallRow, bus.currentBallCol, bus.change, bus.countdown,
                         bus.isdelay, bus.win, bus.lose, bus.lives_left, e.row, e.col, e.change,
                         e.countdown, e.isdelay, e.win, e.lose, e.lives);
            end
        end
    end

    task automatic drive(input bit tick, input bit [3:0] b, input bit rq,
                         input bit [1:0] co, input bit [1:0] td);
        exp_t e;
        int old_r, old_c;
        bit hit, touch;
        bus.frame_tick = tick;
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = b;
        bus.restart = rq;
        bus.collision = co;
        bus.touchdown = td;
        old_r = m_row; old_c = m_col;
        if (rq) begin
            model_restart();
        end else if (tick) begin
            hit = m_hit || (co != 0);
            touch = m_touch || (td != 0);
            m_hit = 0; m_touch = 0;
            case (m_mode)
                G_COUNT: begin
                    m_left--;
                    if (m_left == 0) m_mode = G_PLAY;
                end
                G_PLAY: begin
                    if (touch) begin
                        m_mode = G_WON;
                    end else if (hit) begin
                        m_lives--;
                        m_row = m_prev_r; m_col = m_prev_c;
                        if (m_lives == 0) m_mode = G_LOST;
                        else begin m_mode = G_FREEZE; m_left = DELAY_FRAMES; end
                    end else begin
                        m_prev_r = m_row; m_prev_c = m_col;
                        m_row = clamp(m_row + dir(b[3], b[2]), R, SCREEN_H - 1 - R);
                        m_col = clamp(m_col + dir(b[1], b[0]), R, SCREEN_W - 1 - R);
                    end
                end
                G_FREEZE: begin
                    m_left--;
                    if (m_left == 0) m_mode = G_PLAY;
                end
                default: ;
            endcase
        end else begin
            if (co != 0) m_hit = 1;
            if (td != 0) m_touch = 1;
        end
        e.stamp = cyc + 1;
        e.row = m_row; e.col = m_col; e.lives = m_lives;
        e.change = (m_row != old_r) || (m_col != old_c);
        e.countdown = (m_mode == G_COUNT);
        e.isdelay = (m_mode == G_FREEZE);
        e.win = (m_mode == G_WON);
        e.lose = (m_mode == G_LOST);
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (bus.currentBallRow !== 32'(START_ROW) || bus.currentBallCol !== 32'(START_COL) ||
            bus.change !== 1'b0 || bus.countdown !== 1'b1 || bus.isdelay !== 1'b0 ||
            bus.win !== 1'b0 || bus.lose !== 1'b0 || bus.lives_left !== 2'(LIVES)) begin
            n_fail++;
            $display("FAIL %s got row=%0d col=%0d chg=%b cd=%b dl=%b win=%b lose=%b lives=%0d expected reset values",
                     tag, bus.currentBallRow, bus.currentBallCol, bus.change, bus.countdown,
                     bus.isdelay, bus.win, bus.lose, bus.lives_left);
        end
    endtask

    task automatic release_reset();
        model_restart();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_outputs("reset_values");
    endtask

    task automatic frame(input bit [3:0] b, input bit [1:0] co, input bit [1:0] td);
        drive(0, 4'($urandom), 0, co, td);
        drive(1, b, 0, 0, 0);
    endtask

    task automatic run_countdown();
        repeat (COUNT_FRAMES)
            frame(4'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    endtask

    initial begin
        bit rq;
        bus.frame_tick = 0; bus.restart = 0;
        bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.collision = 0; bus.touchdown = 0;
        release_reset();

        run_countdown();
        repeat (5) frame(4'b0001, 0, 0);
        repeat (120) frame(4'b1000, 0, 0);
        frame(4'b1100, 0, 0);
        frame(4'b0001, 0, 0);
        frame(4'b0000, 2'd1, 0);
        repeat (DELAY_FRAMES) frame(4'b0001, 2'd2, 2'd1);
        frame(4'b0010, 0, 0);
        frame(4'b0000, 2'd3, 0);
        repeat (DELAY_FRAMES) frame(4'($urandom), 0, 0);
        frame(4'b0100, 0, 0);
        frame(4'b0000, 2'd1, 0);
        repeat (3) frame(4'b0101, 0, 0);
        drive(0, 0, 1, 0, 0);

        run_countdown();
        frame(4'b0001, 2'd2, 2'd1);
        repeat (2) frame(4'b1001, 0, 0);
        drive(0, 0, 1, 0, 0);
        run_countdown();
        drive(1, 4'b0001, 0, 0, 2'd3);
        drive(0, 0, 1, 0, 0);
        run_countdown();
        frame(4'b0101, 0, 0);
        drive(1, 4'b0001, 1, 0, 0);
        run_countdown();
        frame(4'b0000, 2'd1, 0);
        repeat (5) frame(4'b0001, 0, 0);

        @(negedge clk); #1 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset_mid_delay");
        release_reset();

        for (int f = 0; f < 1500; f++) begin
            int gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++)
                drive(0, 4'($urandom), ($urandom_range(0, 999) == 0),
                      ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                      ($urandom_range(0, 199) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
            rq = ((m_mode == G_WON || m_mode == G_LOST) && $urandom_range(0, 7) == 0) ||
                 ($urandom_range(0, 499) == 0);
            drive(1, 4'($urandom), rq,
                  ($urandom_range(0, 59) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                  ($urandom_range(0, 299) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
        end

        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
